// File: rtl/apb_slave_regfile_pkg.sv
// Shared types for the APB register-file completer: FSM states, address alignment
// and the classification of illegal accesses.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam int APB_ALIGN_BITS = 2;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_ALIGN,
        ERR_RANGE,
        ERR_RO
    } err_cause_t;

    function automatic err_cause_t classify_access(
        input logic misaligned,
        input logic out_of_range,
        input logic ro_write
    );
        if (misaligned)        return ERR_ALIGN;
        else if (out_of_range) return ERR_RANGE;
        else if (ro_write)     return ERR_RO;
        else                   return ERR_NONE;
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle between the AXI-to-APB requester and the register-file completer.
interface apb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regfile_regbank.sv
// Register storage: read-only ID/status slots, writable control registers,
// commit port and one-cycle write strobes.
module apb_regbank
    import apb_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter int                    IDX_WIDTH  = 3,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           commit,
    input  logic [IDX_WIDTH-1:0]           commit_idx,
    input  logic [DATA_WIDTH-1:0]          commit_data,
    input  logic [DATA_WIDTH-1:0]          status_in,
    input  logic [IDX_WIDTH-1:0]           rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]            wr_strobe
);

    // Only slots 2 and up hold state; 0 and 1 are constant/live.
    logic [DATA_WIDTH-1:0] ctrl_q [2:NUM_REGS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 2; i < NUM_REGS; i++) ctrl_q[i] <= '0;
        end else if (commit) begin
            for (int i = 2; i < NUM_REGS; i++) begin
                if (commit_idx == IDX_WIDTH'(i)) ctrl_q[i] <= commit_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_strobe <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_strobe[i] <= commit && (commit_idx == IDX_WIDTH'(i));
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx == IDX_WIDTH'(0)) begin
            rd_data = ID_VALUE;
        end else if (rd_idx == IDX_WIDTH'(1)) begin
            rd_data = status_in;
        end else begin
            for (int i = 2; i < NUM_REGS; i++) begin
                if (rd_idx == IDX_WIDTH'(i)) rd_data = ctrl_q[i];
            end
        end
    end

    always_comb begin
        regs_out = '0;
        regs_out[0 +: DATA_WIDTH]          = ID_VALUE;
        regs_out[DATA_WIDTH +: DATA_WIDTH] = status_in;
        for (int i = 2; i < NUM_REGS; i++) begin
            regs_out[i*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[i];
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer: one transfer at a time, programmable wait states, PSLVERR on
// misaligned, out-of-range or read-only-write accesses.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    apb_slave_regfile_if.slave             apb,
    input  logic [DATA_WIDTH-1:0]          status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]            wr_strobe
);

    localparam int                    IDX_WIDTH  = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(4 * NUM_REGS);

    state_t                state, state_next;
    logic [3:0]            wait_cnt;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IDX_WIDTH-1:0]  idx_q;

    logic                  setup;
    logic                  commit;
    logic [IDX_WIDTH-1:0]  addr_idx;
    logic [DATA_WIDTH-1:0] bank_rdata;
    err_cause_t            cause;

    assign setup    = apb.PSEL && !apb.PENABLE;
    assign addr_idx = apb.PADDR[APB_ALIGN_BITS +: IDX_WIDTH];
    assign cause    = classify_access(apb.PADDR[APB_ALIGN_BITS-1:0] != '0,
                                      apb.PADDR >= ADDR_LIMIT,
                                      apb.PWRITE && (addr_idx < IDX_WIDTH'(2)));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_next;
    end

    // Dropping PSEL while waiting or completing is a requester abort.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (setup) state_next = (WAIT_STATES == 0) ? DONE : WAIT;
            WAIT: begin
                if (!apb.PSEL)              state_next = IDLE;
                else if (wait_cnt == 4'd1)  state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read data and error are captured at setup so status_in is sampled then.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            idx_q    <= '0;
        end else if (state == IDLE && setup) begin
            wait_cnt <= 4'(WAIT_STATES);
            write_q  <= apb.PWRITE;
            err_q    <= (cause != ERR_NONE);
            wdata_q  <= apb.PWDATA;
            rdata_q  <= (cause != ERR_NONE || apb.PWRITE) ? '0 : bank_rdata;
            idx_q    <= addr_idx;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    assign commit      = (state == DONE) && apb.PSEL && write_q && !err_q;
    assign apb.PREADY  = (state == DONE);
    assign apb.PSLVERR = (state == DONE) && err_q;
    assign apb.PRDATA  = ((state == DONE) && !write_q) ? rdata_q : '0;

    apb_regbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_WIDTH  (IDX_WIDTH),
        .ID_VALUE   (ID_VALUE)
    ) u_regbank (
        .clk         (PCLK),
        .rst_n       (PRESETn),
        .commit      (commit),
        .commit_idx  (idx_q),
        .commit_data (wdata_q),
        .status_in   (status_in),
        .rd_idx      (addr_idx),
        .rd_data     (bank_rdata),
        .regs_out    (regs_out),
        .wr_strobe   (wr_strobe)
    );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (0 and 3 wait states) driven by
// directed APB transfers and checked against a register-map model every cycle.
module tb_apb_slave_regfile;

    localparam int          NR = 8;
    localparam int          DW = 32;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] status_in = '0;

    logic        psel[2], penable[2], pwrite[2];
    logic [31:0] paddr[2], pwdata[2];
    logic        ready[2], slverr[2];
    logic [31:0] prdata[2];

    logic [NR*DW-1:0] regs_out0, regs_out1;
    logic [NR-1:0]    strobe0, strobe1;

    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) bus0 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.PSEL = psel[0];  assign bus0.PENABLE = penable[0];
    assign bus0.PWRITE = pwrite[0];  assign bus0.PADDR = paddr[0];
    assign bus0.PWDATA = pwdata[0];
    assign bus1.PSEL = psel[1];  assign bus1.PENABLE = penable[1];
    assign bus1.PWRITE = pwrite[1];  assign bus1.PADDR = paddr[1];
    assign bus1.PWDATA = pwdata[1];
    assign ready[0] = bus0.PREADY;  assign slverr[0] = bus0.PSLVERR;  assign prdata[0] = bus0.PRDATA;
    assign ready[1] = bus1.PREADY;  assign slverr[1] = bus1.PSLVERR;  assign prdata[1] = bus1.PRDATA;

    apb_slave_regfile #(.NUM_REGS(NR), .WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
        .PCLK(clk), .PRESETn(rst_n), .apb(bus0.slave),
        .status_in(status_in), .regs_out(regs_out0), .wr_strobe(strobe0)
    );

    apb_slave_regfile #(.NUM_REGS(NR), .WAIT_STATES(3), .ID_VALUE(ID)) dut1 (
        .PCLK(clk), .PRESETn(rst_n), .apb(bus1.slave),
        .status_in(status_in), .regs_out(regs_out1), .wr_strobe(strobe1)
    );

    // Model: writable register contents and the strobe expected this cycle.
    logic [31:0]   model_regs[2][NR];
    logic [NR-1:0] exp_strobe[2];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input int d, input int i);
        if (i == 0)      return ID;
        else if (i == 1) return status_in;
        else             return model_regs[d][i];
    endfunction

    function automatic logic [31:0] dut_word(input int d, input int i);
        logic [NR*DW-1:0] img;
        img = (d == 0) ? regs_out0 : regs_out1;
        return img[i*DW +: DW];
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NR; i++) model_regs[d][i] = '0;
            exp_strobe[d] = '0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NR; i++)
                    check($sformatf("regs_out%0d[%0d]", d, i), dut_word(d, i), model_word(d, i));
                check($sformatf("wr_strobe%0d", d), 32'((d == 0) ? strobe0 : strobe1), 32'(exp_strobe[d]));
                if (!ready[d]) begin
                    check($sformatf("pslverr_idle%0d", d), 32'(slverr[d]), 32'd0);
                    check($sformatf("prdata_idle%0d", d), prdata[d], 32'd0);
                end
                exp_strobe[d] = '0;
            end
        end
    end

    task automatic idle_bus();
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0;  pwdata[d] = '0;
        end
    endtask

    // One full APB transfer; returns #1 after the edge that ends the completion cycle.
    task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, output logic [31:0] rd, output logic err);
        int          ws;
        int          idx;
        logic        exp_err;
        logic [31:0] exp_rd;
        ws  = (d == 0) ? 0 : 3;
        idx = int'(addr[4:2]);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
        exp_err = (addr[1:0] != 2'b00) || (addr >= 32'(4 * NR)) || (wr && addr < 32'd8);
        exp_rd  = (exp_err || wr) ? 32'd0 : model_word(d, idx);
        @(posedge clk); #1;
        penable[d] = 1'b1;
        for (int c = 1; c <= ws + 1; c++) begin
            @(negedge clk);
            check($sformatf("pready%0d_cycle%0d", d, c), 32'(ready[d]), 32'(c == ws + 1));
        end
        rd  = prdata[d];
        err = slverr[d];
        check($sformatf("pslverr%0d@%h", d, addr), 32'(err), 32'(exp_err));
        check($sformatf("prdata%0d@%h", d, addr), rd, exp_rd);
        @(posedge clk);
        if (wr && !exp_err) begin
            model_regs[d][idx] = data;
            exp_strobe[d] = NR'(1) << idx;
        end
        #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        err;

    initial begin
        idle_bus();
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_pready%0d", d), 32'(ready[d]), 32'd0);
            check($sformatf("reset_pslverr%0d", d), 32'(slverr[d]), 32'd0);
            check($sformatf("reset_prdata%0d", d), prdata[d], 32'd0);
        end
        check("reset_strobe0", 32'(strobe0), 32'd0);
        check("reset_id_slot", regs_out0[31:0], 32'hA9B0_0001);
        check("reset_ctrl2", regs_out0[95:64], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);

        applyStimulus(0, 1'b1, 32'h08, 32'hDEAD_BEEF, rd, err);
        check("wr08_err_lit", 32'(err), 32'd0);
        check("wr08_strobe_lit", 32'(strobe0), 32'h04);
        check("wr08_reg_lit", regs_out0[95:64], 32'hDEAD_BEEF);
        idle_cycles(2);

        applyStimulus(1, 1'b0, 32'h00, 32'h0, rd, err);
        check("rd00_id_lit", rd, 32'hA9B0_0001);
        idle_cycles(1);

        status_in = 32'h55;
        idle_cycles(1);
        applyStimulus(1, 1'b0, 32'h04, 32'h0, rd, err);
        check("rd04_status_lit", rd, 32'h55);
        applyStimulus(1, 1'b1, 32'h04, 32'h1234, rd, err);
        check("wr04_err_lit", 32'(err), 32'd1);
        check("wr04_nostrobe_lit", 32'(strobe1), 32'd0);
        idle_cycles(1);

        applyStimulus(0, 1'b0, 32'h20, 32'h0, rd, err);
        check("rd20_err_lit", 32'(err), 32'd1);
        check("rd20_data_lit", rd, 32'd0);
        applyStimulus(0, 1'b0, 32'h0A, 32'h0, rd, err);
        check("rd0A_err_lit", 32'(err), 32'd1);
        applyStimulus(0, 1'b0, 32'h8000_0008, 32'h0, rd, err);
        applyStimulus(0, 1'b1, 32'h0000_0100, 32'h77, rd, err);
        applyStimulus(0, 1'b1, 32'h00, 32'h99, rd, err);
        idle_cycles(1);

        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 1'b1, 32'h0C, 32'h12, rd, err);
            applyStimulus(d, 1'b0, 32'h0C, 32'h0, rd, err);
            check($sformatf("b2b_rd0C_lit%0d", d), rd, 32'h12);
        end
        applyStimulus(1, 1'b1, 32'h1C, 32'hA5A5_0F0F, rd, err);
        applyStimulus(1, 1'b0, 32'h1C, 32'h0, rd, err);
        check("rd1C_lit", rd, 32'hA5A5_0F0F);
        status_in = 32'hCAFE_0001;
        applyStimulus(0, 1'b0, 32'h08, 32'h0, rd, err);
        check("rd08_lit", rd, 32'hDEAD_BEEF);
        idle_cycles(1);

        // Reset lands in the completion cycle of a write: no commit, PREADY drops at once.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h10; pwdata[1] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_pready1", 32'(ready[1]), 32'd1);
        rst_n = 1'b0;
        clear_model();
        #1;
        check("reset_drop_pready1", 32'(ready[1]), 32'd0);
        check("reset_drop_pslverr1", 32'(slverr[1]), 32'd0);
        idle_bus();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);
        check("reset_reg10_lit", regs_out1[159:128], 32'd0);
        check("reset_reg0C_lit", regs_out1[127:96], 32'd0);
        applyStimulus(1, 1'b0, 32'h10, 32'h0, rd, err);
        check("post_reset_rd10_lit", rd, 32'd0);
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
